score_event_queue: RTL
======================

Name: score_event_queue

Overview:
- Sits directly upstream of the score block and drives its monster_died_pulse, boss_died_pulse and asteroid_exploded_pulse inputs.
- Collects kill events that can arrive simultaneously: several monsters dying in one frame, a boss and an asteroid in the same cycle.
- Serialises them into at most one single-cycle pulse per emission slot, so that no point is lost when the score counter collapses coincident pulses into one increment.
- Boss kills expand into BOSS_POINTS separate pulses.

Parameters:
- MONSTER_AMOUNT, 8, width of the per-monster death vector.
- PENDING_WIDTH, 5, width of each pending-event counter; saturates at 2^PENDING_WIDTH-1.
- BOSS_POINTS, 5, number of boss pulses queued per boss kill; must be at least 1 and at most 2^PENDING_WIDTH-1.
- PULSE_GAP, 1, idle cycles forced after every emitted pulse so digit carries settle; 0 is legal.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, active-low; all state clears asynchronously.
- monster_died  in  MONSTER_AMOUNT  one bit per monster; each bit is a single-cycle death pulse; any number of bits may be set together.
- boss_died_in  in  1  single-cycle boss death pulse.
- asteroid_exploded_in  in  1  single-cycle asteroid explosion pulse.
- game_over  in  1  level; freezes and flushes the queue.
- monster_died_pulse  out  1  to score; one pulse per queued monster kill.
- boss_died_pulse  out  1  to score; one pulse per queued boss point.
- asteroid_exploded_pulse  out  1  to score; one pulse per queued asteroid.
- busy  out  1  high while any pending counter is nonzero or the block is in GAP.
- dropped  out  1  sticky; set when an arrival is lost to saturation; cleared only by reset.

Behaviour:
Interface:
- One clock, clk.
- Reset resetN is asynchronous and active-low.

Reset:
- All three pending counters are 0.
- State is IDLE and the gap counter is 0.
- All outputs are 0.

Counters:
- Three counters: pend_m, pend_b, pend_a.
- Arrivals each cycle: m_in = popcount(monster_died), b_in = BOSS_POINTS if boss_died_in else 0, a_in = asteroid_exploded_in.
- Update per counter: next = sat(pend + in - emitted_this_cycle).
- Compute the sum at PENDING_WIDTH+MONSTER_AMOUNT bits. Clamp to the range 0..2^PENDING_WIDTH-1.
- Any clamp from above sets dropped.
- Arrival and emission on the same counter in the same cycle both take effect, giving a net pend + in - 1.

State machine (registered outputs; at most one output high in any cycle):
- IDLE:
  - If game_over=0 and any counter (after this cycle's arrivals) is nonzero, go to EMIT.
  - An arrival at cycle t therefore produces its pulse at cycle t+2 at the earliest; this is the fixed latency.
- EMIT:
  - Assert exactly one output for one cycle. Fixed priority: boss > monster > asteroid.
  - Decrement the chosen counter.
  - If PULSE_GAP>0, go to GAP with gap counter = PULSE_GAP.
  - If PULSE_GAP=0, stay in EMIT while work remains, otherwise go to IDLE.
- GAP:
  - All outputs 0; decrement the gap counter.
  - When it reaches 0, go to EMIT if work remains, else IDLE.

Throughput:
- One pulse per PULSE_GAP+1 cycles.
- Arrivals continue to accumulate during EMIT and GAP.

game_over:
- While high in any state, all outputs are forced to 0 that same cycle (combinational gate on the registered outputs).
- Counters clear to 0, state goes to IDLE, and arrivals are ignored.
- When game_over deasserts, the block starts empty.

Asynchronous reset mid-burst:
- Remaining pending events are discarded.
- No partial pulse appears; outputs go to 0 immediately.

Test Plan:
- Reset, then one pulse on monster_died[3] at cycle 10 with PULSE_GAP=1 -> monster_died_pulse high only at cycle 12; busy high cycles 11..13; then idle.
- monster_died=8'hFF for one cycle -> exactly 8 monster_died_pulse, each one cycle wide, spaced 2 cycles apart; no other outputs.
- boss_died_in, asteroid_exploded_in and monster_died=8'h01 all in the same cycle -> 5 boss pulses first, then 1 monster pulse, then 1 asteroid pulse; 7 pulses total; never two outputs high together.
- Saturation with PENDING_WIDTH=3: monster_died=8'hFF twice in consecutive cycles -> pend_m clamps at 7; dropped=1 and stays 1; total pulses = 7 + (pulses emitted before the clamp).
- game_over raised after 3 of 8 pulses -> outputs are 0 in the same cycle; busy=0 next cycle; after game_over drops, no further pulses are emitted; arrivals during game_over are ignored.
- resetN pulsed low mid-burst, asynchronous to clk -> outputs 0 immediately; busy=0, dropped=0; a new arrival after release gives normal 2-cycle latency.

Source files
------------

// File: rtl/score_event_queue.sv
// -----------------------------------------------------------------------------
// score_event_queue
//
// Purpose:
//   Collects kill events that may coincide in a single cycle (several monsters,
//   a boss, an asteroid) and replays them to the score block as a stream of
//   single-cycle pulses, at most one pulse per emission slot. This way the score
//   counter never merges coincident events into one increment. A boss kill
//   expands into BOSS_POINTS separate boss pulses.
//
// Ports:
//   clk                     in   system clock
//   resetN                  in   asynchronous active-low reset
//   monster_died            in   [MONSTER_AMOUNT] per-monster death pulses
//   boss_died_in            in   boss death pulse
//   asteroid_exploded_in    in   asteroid explosion pulse
//   game_over               in   level; gates outputs and flushes the queue
//   monster_died_pulse      out  one pulse per queued monster kill
//   boss_died_pulse         out  one pulse per queued boss point
//   asteroid_exploded_pulse out  one pulse per queued asteroid
//   busy                    out  work pending or inter-pulse gap in progress
//   dropped                 out  sticky; an arrival was lost to saturation
// -----------------------------------------------------------------------------
module score_event_queue #(
  parameter int MONSTER_AMOUNT = 8,
  parameter int PENDING_WIDTH  = 5,
  parameter int BOSS_POINTS    = 5,
  parameter int PULSE_GAP      = 1
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [MONSTER_AMOUNT-1:0] monster_died,
  input  logic                      boss_died_in,
  input  logic                      asteroid_exploded_in,
  input  logic                      game_over,
  output logic                      monster_died_pulse,
  output logic                      boss_died_pulse,
  output logic                      asteroid_exploded_pulse,
  output logic                      busy,
  output logic                      dropped
);

  // Wide enough that pend + arrivals can never wrap before clamping.
  localparam int SUM_W = PENDING_WIDTH + MONSTER_AMOUNT;
  localparam int GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP + 1) : 1;
  localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'((1 << PENDING_WIDTH) - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE     = 2'd0,
    EV_MONSTER  = 2'd1,
    EV_BOSS     = 2'd2,
    EV_ASTEROID = 2'd3
  } event_e;

  state_e                   state_q, state_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic [PENDING_WIDTH-1:0] pend_m_q, pend_m_d;
  logic [PENDING_WIDTH-1:0] pend_b_q, pend_b_d;
  logic [PENDING_WIDTH-1:0] pend_a_q, pend_a_d;
  logic                     dropped_q, dropped_d;
  logic                     m_pulse_q, m_pulse_d;
  logic                     b_pulse_q, b_pulse_d;
  logic                     a_pulse_q, a_pulse_d;

  logic [SUM_W-1:0]         m_in, b_in, a_in;
  logic                     m_ovf, b_ovf, a_ovf;
  logic                     work;
  event_e                   emit_sel;

  // Returns {overflow, next_count}: pend + arrivals, minus one when this counter
  // is emitted, clamped to 0..PEND_MAX. The MSB flags a clamp from above.
  function automatic logic [PENDING_WIDTH:0] sat_next(
    input logic [PENDING_WIDTH-1:0] pend,
    input logic [SUM_W-1:0]         arrivals,
    input logic                     take
  );
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(pend) + arrivals;
    if (take && (sum != '0)) sum = sum - SUM_W'(1);
    if (sum > PEND_MAX) return {1'b1, {PENDING_WIDTH{1'b1}}};
    return {1'b0, sum[PENDING_WIDTH-1:0]};
  endfunction

  // Arrivals for this cycle.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path can leave it holding a value (which would infer a latch).
    m_in = '0;
    for (int i = 0; i < MONSTER_AMOUNT; i++) begin
      m_in = m_in + SUM_W'(monster_died[i]);
    end
  end

  assign b_in = boss_died_in ? SUM_W'(BOSS_POINTS) : '0;
  assign a_in = SUM_W'(asteroid_exploded_in);

  // Next-state, counter update and registered-output logic.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    emit_sel  = EV_NONE;
    m_pulse_d = 1'b0;
    b_pulse_d = 1'b0;
    a_pulse_d = 1'b0;

    // The emission choice only looks at registered counts, so an arrival in
    // this cycle can never be emitted in the same cycle.
    if (state_q == ST_EMIT) begin
      if (pend_b_q != '0)      emit_sel = EV_BOSS;
      else if (pend_m_q != '0) emit_sel = EV_MONSTER;
      else if (pend_a_q != '0) emit_sel = EV_ASTEROID;
    end

    {m_ovf, pend_m_d} = sat_next(pend_m_q, m_in, emit_sel == EV_MONSTER);
    {b_ovf, pend_b_d} = sat_next(pend_b_q, b_in, emit_sel == EV_BOSS);
    {a_ovf, pend_a_d} = sat_next(pend_a_q, a_in, emit_sel == EV_ASTEROID);
    dropped_d = dropped_q | m_ovf | b_ovf | a_ovf;

    work = (pend_m_d != '0) || (pend_b_d != '0) || (pend_a_d != '0);

    m_pulse_d = (emit_sel == EV_MONSTER);
    b_pulse_d = (emit_sel == EV_BOSS);
    a_pulse_d = (emit_sel == EV_ASTEROID);

    unique case (state_q)
      ST_IDLE: begin
        if (work) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (PULSE_GAP > 0) begin
          state_d = ST_GAP;
          gap_d   = GAP_W'(PULSE_GAP);
        end else begin
          state_d = work ? ST_EMIT : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          // Trailing gap cycle reached with nothing queued: return to idle
          // unless work turned up meanwhile.
          state_d = work ? ST_EMIT : ST_IDLE;
        end else if (gap_q == GAP_W'(1)) begin
          // Last forced-idle cycle. With work queued the next slot opens right
          // away; otherwise hold GAP one more cycle so busy still covers the
          // settle time behind the final pulse.
          gap_d   = '0;
          state_d = work ? ST_EMIT : ST_GAP;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gap_d   = '0;
      end
    endcase

    // game_over flushes everything; arrivals are ignored so nothing can drop.
    if (game_over) begin
      state_d   = ST_IDLE;
      gap_d     = '0;
      pend_m_d  = '0;
      pend_b_d  = '0;
      pend_a_d  = '0;
      m_pulse_d = 1'b0;
      b_pulse_d = 1'b0;
      a_pulse_d = 1'b0;
      dropped_d = dropped_q;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      gap_q     <= '0;
      pend_m_q  <= '0;
      pend_b_q  <= '0;
      pend_a_q  <= '0;
      dropped_q <= 1'b0;
      m_pulse_q <= 1'b0;
      b_pulse_q <= 1'b0;
      a_pulse_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of every other register, independent of statement order.
      state_q   <= state_d;
      gap_q     <= gap_d;
      pend_m_q  <= pend_m_d;
      pend_b_q  <= pend_b_d;
      pend_a_q  <= pend_a_d;
      dropped_q <= dropped_d;
      m_pulse_q <= m_pulse_d;
      b_pulse_q <= b_pulse_d;
      a_pulse_q <= a_pulse_d;
    end
  end

  // Registered pulses, gated combinationally so game_over silences them within
  // the same cycle it rises.
  assign monster_died_pulse      = m_pulse_q & ~game_over;
  assign boss_died_pulse         = b_pulse_q & ~game_over;
  assign asteroid_exploded_pulse = a_pulse_q & ~game_over;

  assign busy    = (pend_m_q != '0) || (pend_b_q != '0) || (pend_a_q != '0) ||
                   (state_q == ST_GAP);
  assign dropped = dropped_q;

endmodule
